// File: rtl/vm_char_writer.sv
// Character writer: turns a byte stream into video-memory writes with cursor tracking,
// CR/LF/BS handling and form-feed screen clear. Define VM_WRITER_LINE_CLEAR_EN to blank each new row.
module vm_char_writer #(
  parameter int unsigned CH_WIDTH_SCREEN  = 106,
  parameter int unsigned CH_HEIGHT_SCREEN = 40,
  parameter int unsigned CH_SCREENSIZE    = CH_WIDTH_SCREEN * CH_HEIGHT_SCREEN
) (
  input  logic        write_clk,
  input  logic        rst_n,
  input  logic [7:0]  tx_ch,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [12:0] vm_wr_addr,
  output logic [7:0]  vm_ch_out,
  output logic        vm_ch_write_enable,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);

  localparam int unsigned AW = 13;
  localparam int unsigned CW = 7;
  localparam int unsigned RW = 6;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_LINE   = 2'd1,
    CLR_SCREEN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [CW-1:0]   col_d;
  logic [RW-1:0]   row_d;
  logic [AW-1:0]   addr_d;
  logic [7:0]      ch_d;
  logic            we_d;
  logic            ready_d;
  logic            row_adv;
  logic [AW-1:0]   cur_addr;
  logic [RW-1:0]   next_row;

  // Linear cell index of the cursor and the row that follows it (wrapping, no scroll)
  assign cur_addr = AW'(AW'(cursor_row) * AW'(CH_WIDTH_SCREEN)) + AW'(cursor_col);
  assign next_row = (cursor_row == RW'(CH_HEIGHT_SCREEN - 1)) ? '0 : cursor_row + RW'(1);

  // State and output registers
  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      clr_addr_q         <= '0;
      clr_cnt_q          <= '0;
      cursor_col         <= '0;
      cursor_row         <= '0;
      vm_wr_addr         <= '0;
      vm_ch_out          <= '0;
      vm_ch_write_enable <= 1'b0;
      tx_ready           <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state_q            <= state_d;
      clr_addr_q         <= clr_addr_d;
      clr_cnt_q          <= clr_cnt_d;
      cursor_col         <= col_d;
      cursor_row         <= row_d;
      vm_wr_addr         <= addr_d;
      vm_ch_out          <= ch_d;
      vm_ch_write_enable <= we_d;
      tx_ready           <= ready_d;
      busy               <= !ready_d;
    end
  end

  // Next-state, cursor and write decode
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_cnt_d  = clr_cnt_q;
    col_d      = cursor_col;
    row_d      = cursor_row;
    addr_d     = vm_wr_addr;
    ch_d       = vm_ch_out;
    we_d       = 1'b0;
    row_adv    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          case (tx_ch)
            CH_CR: col_d = '0;
            CH_LF: begin
              col_d   = '0;
              row_adv = 1'b1;
            end
            CH_BS: begin
              if (cursor_col != '0) begin
                col_d  = cursor_col - CW'(1);
                we_d   = 1'b1;
                addr_d = cur_addr - AW'(1);
                ch_d   = CH_SPACE;
              end
            end
            CH_FF: begin
              state_d    = CLR_SCREEN;
              clr_addr_d = '0;
            end
            default: begin
              we_d   = 1'b1;
              addr_d = cur_addr;
              ch_d   = tx_ch;
              if (cursor_col == CW'(CH_WIDTH_SCREEN - 1)) begin
                col_d   = '0;
                row_adv = 1'b1;
              end else begin
                col_d = cursor_col + CW'(1);
              end
            end
          endcase
        end
      end
      CLR_LINE: begin
        we_d       = 1'b1;
        addr_d     = clr_addr_q;
        ch_d       = CH_SPACE;
        clr_addr_d = clr_addr_q + AW'(1);
        clr_cnt_d  = clr_cnt_q + CW'(1);
        if (clr_cnt_q == CW'(CH_WIDTH_SCREEN - 1)) state_d = IDLE;
      end
      CLR_SCREEN: begin
        we_d       = 1'b1;
        addr_d     = clr_addr_q;
        ch_d       = CH_SPACE;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == AW'(CH_SCREENSIZE - 1)) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (row_adv) begin
      row_d = next_row;
`ifdef VM_WRITER_LINE_CLEAR_EN
      state_d    = CLR_LINE;
      clr_addr_d = AW'(AW'(next_row) * AW'(CH_WIDTH_SCREEN));
      clr_cnt_d  = '0;
`endif
    end

    ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_vm_char_writer.sv
// Directed bench for vm_char_writer; expectations follow VM_WRITER_LINE_CLEAR_EN when defined.
module tb_vm_char_writer;

  logic        write_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tx_ch;
  logic        tx_valid;
  logic        tx_ready;
  logic [12:0] vm_wr_addr;
  logic [7:0]  vm_ch_out;
  logic        vm_ch_write_enable;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  int checks = 0;
  int errors = 0;

  vm_char_writer dut (
    .write_clk          (write_clk),
    .rst_n              (rst_n),
    .tx_ch              (tx_ch),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .vm_wr_addr         (vm_wr_addr),
    .vm_ch_out          (vm_ch_out),
    .vm_ch_write_enable (vm_ch_write_enable),
    .cursor_col         (cursor_col),
    .cursor_row         (cursor_row),
    .busy               (busy)
  );

  always #5 write_clk = ~write_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Hold a byte valid until the block accepts it
  task automatic send(input logic [7:0] c);
    int   n;
    logic acc;
    n        = 0;
    tx_ch    = c;
    tx_valid = 1'b1;
    do begin
      acc = tx_ready;
      tick();
      n++;
    end while (!acc && n < 5000);
    tx_valid = 1'b0;
    if (!acc) check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!tx_ready && n < 5000) begin
      tick();
      n++;
    end
    check("wait_idle", 32'(tx_ready), 32'd1);
  endtask

  initial begin
    int bad;
    int cnt;
    logic [7:0] v;

    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_ch    = 8'h00;

    // Reset values
    #3;
    check("rst_we",    32'(vm_ch_write_enable), 32'd0);
    check("rst_addr",  32'(vm_wr_addr),         32'd0);
    check("rst_data",  32'(vm_ch_out),          32'd0);
    check("rst_ready", 32'(tx_ready),           32'd0);
    check("rst_col",   32'(cursor_col),         32'd0);
    check("rst_row",   32'(cursor_row),         32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(tx_ready), 32'd1);

    // Single printable byte
    send(8'h41);
    check("a_we",   32'(vm_ch_write_enable), 32'd1);
    check("a_addr", 32'(vm_wr_addr),         32'd0);
    check("a_data", 32'(vm_ch_out),          32'h41);
    check("a_col",  32'(cursor_col),         32'd1);
    check("a_row",  32'(cursor_row),         32'd0);
    tick();
    check("a_we_drop", 32'(vm_ch_write_enable), 32'd0);

    // Full row back-to-back, wrap to next row
    do_reset();
    bad = 0;
    tx_valid = 1'b1;
    for (int i = 0; i < 106; i++) begin
      v = 8'h41 + 8'(i % 26);
      tx_ch = v;
      tick();
      if (!(vm_ch_write_enable === 1'b1 && vm_wr_addr === 13'(i) && vm_ch_out === v)) bad++;
    end
    tx_valid = 1'b0;
    check("row_writes_bad", 32'(bad), 32'd0);
    check("row_col", 32'(cursor_col), 32'd0);
    check("row_row", 32'(cursor_row), 32'd1);
`ifdef VM_WRITER_LINE_CLEAR_EN
    bad = 0;
    cnt = 0;
    for (int k = 0; k < 106; k++) begin
      if (!tx_ready) cnt++;
      tick();
      if (!(vm_ch_write_enable === 1'b1 && vm_wr_addr === 13'(106 + k) && vm_ch_out === 8'h20)) bad++;
    end
    if (!tx_ready) cnt++;
    check("row_clr_bad", 32'(bad), 32'd0);
    check("row_clr_ready_low", 32'(cnt), 32'd106);
`else
    check("row_ready", 32'(tx_ready), 32'd1);
    tick();
    check("row_no_write", 32'(vm_ch_write_enable), 32'd0);
`endif

    // LF from the last row wraps to row 0
    do_reset();
    for (int i = 0; i < 39; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h78);
    check("pre_lf_row", 32'(cursor_row), 32'd39);
    check("pre_lf_col", 32'(cursor_col), 32'd5);
    send(8'h0A);
    check("lf_row", 32'(cursor_row), 32'd0);
    check("lf_col", 32'(cursor_col), 32'd0);
    check("lf_we",  32'(vm_ch_write_enable), 32'd0);
`ifdef VM_WRITER_LINE_CLEAR_EN
    bad = 0;
    for (int k = 0; k < 106; k++) begin
      tick();
      if (!(vm_ch_write_enable === 1'b1 && vm_wr_addr === 13'(k) && vm_ch_out === 8'h20)) bad++;
    end
    check("lf_clr_bad", 32'(bad), 32'd0);
`else
    check("lf_ready", 32'(tx_ready), 32'd1);
`endif

    // Backspace at column 0 and mid-row, then CR
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h0A);
    wait_idle();
    send(8'h08);
    check("bs0_we",  32'(vm_ch_write_enable), 32'd0);
    check("bs0_col", 32'(cursor_col),         32'd0);
    check("bs0_row", 32'(cursor_row),         32'd3);
    for (int i = 0; i < 4; i++) send(8'h30 + 8'(i));
    check("bs_pre_col", 32'(cursor_col), 32'd4);
    send(8'h08);
    check("bs_we",   32'(vm_ch_write_enable), 32'd1);
    check("bs_addr", 32'(vm_wr_addr),         32'd321);
    check("bs_data", 32'(vm_ch_out),          32'h20);
    check("bs_col",  32'(cursor_col),         32'd3);
    check("bs_row",  32'(cursor_row),         32'd3);
    send(8'h0D);
    check("cr_we",  32'(vm_ch_write_enable), 32'd0);
    check("cr_col", 32'(cursor_col),         32'd0);
    check("cr_row", 32'(cursor_row),         32'd3);

    // Form feed with a byte held pending during the clear
    wait_idle();
    tx_valid = 1'b1;
    tx_ch    = 8'h0C;
    tick();
    tx_ch = 8'h5A;
    check("ff_busy",  32'(busy),               32'd1);
    check("ff_ready", 32'(tx_ready),           32'd0);
    check("ff_we",    32'(vm_ch_write_enable), 32'd0);
    bad = 0;
    cnt = busy ? 1 : 0;
    for (int i = 0; i < 4240; i++) begin
      tick();
      if (!(vm_ch_write_enable === 1'b1 && vm_wr_addr === 13'(i) && vm_ch_out === 8'h20)) bad++;
      if (vm_wr_addr > 13'd4239) bad++;
      if (busy) cnt++;
    end
    check("ff_writes_bad", 32'(bad), 32'd0);
    check("ff_busy_cycles", 32'(cnt), 32'd4240);
    check("ff_done_ready", 32'(tx_ready),  32'd1);
    check("ff_col", 32'(cursor_col), 32'd0);
    check("ff_row", 32'(cursor_row), 32'd0);
    tick();
    tx_valid = 1'b0;
    check("held_we",   32'(vm_ch_write_enable), 32'd1);
    check("held_addr", 32'(vm_wr_addr),         32'd0);
    check("held_data", 32'(vm_ch_out),          32'h5A);
    check("held_col",  32'(cursor_col),         32'd1);
    tick();
    check("held_once", 32'(vm_ch_write_enable), 32'd0);
    check("held_col2", 32'(cursor_col),         32'd1);

    // Reset in the middle of a screen clear
    wait_idle();
    send(8'h0C);
    for (int i = 0; i < 100; i++) tick();
    check("mid_we",   32'(vm_ch_write_enable), 32'd1);
    check("mid_addr", 32'(vm_wr_addr),         32'd99);
    rst_n = 1'b0;
    #2;
    check("abort_we",    32'(vm_ch_write_enable), 32'd0);
    check("abort_addr",  32'(vm_wr_addr),         32'd0);
    check("abort_data",  32'(vm_ch_out),          32'd0);
    check("abort_ready", 32'(tx_ready),           32'd0);
    check("abort_col",   32'(cursor_col),         32'd0);
    check("abort_row",   32'(cursor_row),         32'd0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vm_ch_write_enable) cnt++;
    end
    check("abort_no_writes", 32'(cnt), 32'd0);
    check("abort_idle_ready", 32'(tx_ready), 32'd1);
    check("abort_idle_busy",  32'(busy),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vm_char_writer.md
VM_CHAR_WRITER -- requirements
Module: vm_char_writer

Interface
REQ-001 Parameter CH_WIDTH_SCREEN, default 106, meaning character columns per screen.
REQ-002 Parameter CH_HEIGHT_SCREEN, default 40, meaning character rows per screen.
REQ-003 Parameter CH_SCREENSIZE, default CH_WIDTH_SCREEN*CH_HEIGHT_SCREEN (4240), meaning number of video-memory cells.
REQ-004 write_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 tx_ch  input  8  incoming character byte.
REQ-007 tx_valid  input  1  tx_ch valid.
REQ-008 tx_ready  output  1  block accepts tx_ch this cycle.
REQ-009 vm_wr_addr  output  13  video-memory cell index, row*CH_WIDTH_SCREEN+col.
REQ-010 vm_ch_out  output  8  byte to write, drives video-memory vm_ch_in.
REQ-011 vm_ch_write_enable  output  1  one-cycle write strobe, sampled by memory on write_clk.
REQ-012 cursor_col  output  7  current column, 0..CH_WIDTH_SCREEN-1.
REQ-013 cursor_row  output  6  current row, 0..CH_HEIGHT_SCREEN-1.
REQ-014 busy  output  1  high while a clear sequence is running.

Function
REQ-015 States SHALL be IDLE, CLR_LINE, CLR_SCREEN; tx_ready SHALL equal (state==IDLE) and busy SHALL equal its inverse.
REQ-016 Transfer SHALL occur on a rising edge with tx_valid && tx_ready; tx_ch is ignored otherwise.
REQ-017 Printable byte (any value except 0x08, 0x0A, 0x0C, 0x0D): on the transfer edge, outputs SHALL register vm_ch_write_enable=1, vm_ch_out=tx_ch, vm_wr_addr=cursor position; cursor SHALL advance on the same edge; latency 1 cycle; back-to-back transfers every cycle SHALL be supported.
REQ-018 vm_ch_write_enable SHALL be high for exactly one cycle per write and low in every cycle with no write.
REQ-019 Column advance from CH_WIDTH_SCREEN-1 SHALL set col=0 and perform row advance.
REQ-020 Row advance from CH_HEIGHT_SCREEN-1 SHALL wrap to row 0 (no scrolling).
REQ-021 0x0D (CR): col=0, no write.
REQ-022 0x0A (LF): col=0 and row advance, no write.
REQ-023 0x08 (BS): col>0 -> col=col-1 and write 0x20 at the new position; col==0 -> no action, no write.
REQ-024 0x0C (FF): enter CLR_SCREEN; write 0x20 to addresses 0..CH_SCREENSIZE-1, one per cycle, ascending; after address CH_SCREENSIZE-1, cursor=(0,0), return to IDLE.
REQ-025 Address arithmetic SHALL be unsigned 13-bit; vm_wr_addr SHALL never exceed CH_SCREENSIZE-1.
REQ-026 tx_valid asserted while busy SHALL be held off (tx_ready low) with no loss or duplication of the pending byte.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, cursor_col=0, cursor_row=0, vm_wr_addr=0, vm_ch_out=0, vm_ch_write_enable=0, tx_ready=0 while asserted.
REQ-028 tx_ready SHALL rise on the first write_clk edge after rst_n deasserts.
REQ-029 Reset mid-clear SHALL abort the sequence; no further writes until a new transfer.
REQ-030 Reset SHALL NOT clear video memory.

Configuration
REQ-031 Macro VM_WRITER_LINE_CLEAR_EN defined: every row advance (REQ-019, REQ-022) SHALL enter CLR_LINE, writing 0x20 to the CH_WIDTH_SCREEN cells of the new row, col 0 upward, one per cycle, then return to IDLE with cursor at (new row, 0).
REQ-032 Macro undefined: row advance SHALL update the cursor only, no clear writes, tx_ready stays high; all other behaviour identical.

Verification
REQ-033 Reset, send 'A' (0x41) -> next cycle we=1, addr=0, data=0x41; cursor (0,1).
REQ-034 Send 106 printable bytes back-to-back -> writes at addr 0..105, cursor (1,0); with VM_WRITER_LINE_CLEAR_EN, 106 writes of 0x20 at addr 106..211 and tx_ready low exactly 106 cycles.
REQ-035 Cursor (39,5), send 0x0A -> cursor (0,0); with macro, clears addr 0..105; without, no write.
REQ-036 Cursor (3,0), send 0x08 -> no write, cursor unchanged; cursor (3,4), send 0x08 -> write 0x20 at addr 321, cursor (3,3).
REQ-037 Send 0x0C -> 4240 writes of 0x20 at addr 0..4239, busy high 4240 cycles, cursor (0,0); pulse rst_n low at clear cycle 100 -> writes stop, all outputs at reset values.
